// File: rtl/rpi_byte_to_block_pkg.sv
// Shared constants for the Raspberry Pi byte-to-block packer: block size,
// padding byte and the FSM state encoding.
package rpi_byte_to_block_pkg;

   localparam int BLOCK_BYTES = 32;
   localparam logic [7:0] PAD_BYTE = 8'h80;

   localparam logic [1:0] ST_COLLECT    = 2'd0;
   localparam logic [1:0] ST_PAD        = 2'd1;
   localparam logic [1:0] ST_OUT        = 2'd2;
   localparam logic [1:0] ST_OUT_PADBLK = 2'd3;

   // Block made only of padding: 0x80 in byte 0, zeros everywhere else.
   function automatic logic [8*BLOCK_BYTES-1:0] pad_block();
      return {PAD_BYTE, {(8*BLOCK_BYTES-8){1'b0}}};
   endfunction

endpackage

// File: rtl/rpi_byte_to_block_sync_edge.sv
// N-stage synchronizer followed by a registered rising-edge pulse.
// Edge detection stays disarmed after reset until the synchronized input has
// been seen low with genuine samples, so a level already high at reset
// release never produces a pulse.
module rpi_byte_to_block_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic [STAGES-1:0] sync_reg;
   logic [STAGES-1:0] fill_reg;
   logic              armed_reg;
   logic              prev_reg;
   logic              pulse_reg;

   // Synchronizer chain plus a parallel fill marker tracking when the last
   // stage holds a real sample rather than the reset value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_reg <= '0;
         fill_reg <= '0;
      end else begin
         sync_reg[0] <= din;
         fill_reg[0] <= 1'b1;
         for (int i = 1; i < STAGES; i++) begin
            sync_reg[i] <= sync_reg[i-1];
            fill_reg[i] <= fill_reg[i-1];
         end
      end
   end

   // Arm on the first genuine low level, then register rising edges.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         armed_reg <= 1'b0;
         prev_reg  <= 1'b0;
         pulse_reg <= 1'b0;
      end else begin
         if (fill_reg[STAGES-1] && !sync_reg[STAGES-1]) begin
            armed_reg <= 1'b1;
         end
         prev_reg  <= sync_reg[STAGES-1];
         pulse_reg <= armed_reg & sync_reg[STAGES-1] & ~prev_reg;
      end
   end

   assign pulse = pulse_reg;

endmodule

// File: rtl/rpi_byte_to_block.sv
// Collects bytes strobed in asynchronously by a Raspberry Pi into 32-byte
// message blocks for a CubeHash-256 core, appending 0x80 padding after the
// final byte (an extra padding-only block when the message fills a block).
module rpi_byte_to_block #(
   parameter int SYNC_STAGES = 2,
   parameter int BLOCK_BYTES = rpi_byte_to_block_pkg::BLOCK_BYTES
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               rpi_data,
   input  logic                     rpi_load,
   input  logic                     rpi_last,
   input  logic                     blk_ready,
   output logic [8*BLOCK_BYTES-1:0] blk_data,
   output logic                     blk_valid,
   output logic                     blk_last,
   output logic                     rpi_busy,
   output logic                     ovf_err
);
   import rpi_byte_to_block_pkg::*;

   logic [8:0]                  dsync_reg [SYNC_STAGES];
   logic                        load_pulse;
   logic [7:0]                  in_byte;
   logic                        in_last;

   logic [1:0]                  state_reg;
   logic [1:0]                  state_next;
   logic [5:0]                  byte_cnt_reg;
   logic [5:0]                  cnt_inc;
   logic [0:BLOCK_BYTES-1][7:0] blk_reg;
   logic                        blk_valid_reg;
   logic                        blk_last_reg;
   logic                        pad_pending_reg;
   logic                        ovf_reg;
   logic                        hs;
   logic                        accept;
   logic                        block_full;

   rpi_byte_to_block_sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (rpi_load),
      .pulse (load_pulse)
   );

   // Plain synchronizer stages for the data byte and the last flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            dsync_reg[i] <= '0;
         end
      end else begin
         dsync_reg[0] <= {rpi_last, rpi_data};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            dsync_reg[i] <= dsync_reg[i-1];
         end
      end
   end

   assign in_byte = dsync_reg[SYNC_STAGES-1][7:0];
   assign in_last = dsync_reg[SYNC_STAGES-1][8];

   // Next-state decode; a ready seen while nothing is offered is ignored.
   always_comb begin
      hs         = blk_valid_reg & blk_ready;
      accept     = load_pulse & (state_reg == ST_COLLECT);
      cnt_inc    = byte_cnt_reg + 6'd1;
      block_full = (cnt_inc == 6'(BLOCK_BYTES));
      state_next = state_reg;
      case (state_reg)
         ST_COLLECT: begin
            if (accept) begin
               if (in_last && !block_full) begin
                  state_next = ST_PAD;
               end else if (block_full) begin
                  state_next = ST_OUT;
               end
            end
         end
         ST_PAD: state_next = ST_OUT;
         ST_OUT: begin
            if (hs) begin
               state_next = pad_pending_reg ? ST_OUT_PADBLK : ST_COLLECT;
            end
         end
         ST_OUT_PADBLK: begin
            if (hs) begin
               state_next = ST_COLLECT;
            end
         end
         default: state_next = ST_COLLECT;
      endcase
   end

   // Block assembly, padding, handshake bookkeeping and the sticky overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= ST_COLLECT;
         byte_cnt_reg    <= '0;
         blk_reg         <= '0;
         blk_valid_reg   <= 1'b0;
         blk_last_reg    <= 1'b0;
         pad_pending_reg <= 1'b0;
         ovf_reg         <= 1'b0;
      end else begin
         state_reg <= state_next;
         // Valid drops for at least one cycle after every handshake.
         blk_valid_reg <= ((state_next == ST_OUT) || (state_next == ST_OUT_PADBLK)) && !hs;
         if (load_pulse && (state_reg != ST_COLLECT)) begin
            ovf_reg <= 1'b1;
         end
         case (state_reg)
            ST_COLLECT: begin
               if (accept) begin
                  for (int i = 0; i < BLOCK_BYTES; i++) begin
                     if (6'(i) == byte_cnt_reg) begin
                        blk_reg[i] <= in_byte;
                     end
                  end
                  byte_cnt_reg <= cnt_inc;
                  if (in_last && block_full) begin
                     pad_pending_reg <= 1'b1;
                  end
               end
            end
            ST_PAD: begin
               for (int i = 0; i < BLOCK_BYTES; i++) begin
                  if (6'(i) == byte_cnt_reg) begin
                     blk_reg[i] <= PAD_BYTE;
                  end else if (6'(i) > byte_cnt_reg) begin
                     blk_reg[i] <= 8'h00;
                  end
               end
               blk_last_reg <= 1'b1;
            end
            ST_OUT: begin
               if (hs) begin
                  byte_cnt_reg <= '0;
                  blk_reg      <= '0;
                  blk_last_reg <= 1'b0;
               end
            end
            ST_OUT_PADBLK: begin
               if (hs) begin
                  pad_pending_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign blk_data  = (state_reg == ST_OUT_PADBLK) ? pad_block() : blk_reg;
   assign blk_valid = blk_valid_reg;
   assign blk_last  = blk_last_reg | (state_reg == ST_OUT_PADBLK);
   assign rpi_busy  = (state_reg != ST_COLLECT);
   assign ovf_err   = ovf_reg;

endmodule

// File: tb/tb_rpi_byte_to_block.sv
// Randomized bench for rpi_byte_to_block: messages are padded and split into
// blocks by a message-level model, and every handshaked block is compared.
module tb_rpi_byte_to_block;

   localparam int SYNC_STAGES = 2;

   logic         clk;
   logic         rst_n;
   logic [7:0]   rpi_data;
   logic         rpi_load;
   logic         rpi_last;
   logic         blk_ready;
   logic [255:0] blk_data;
   logic         blk_valid;
   logic         blk_last;
   logic         rpi_busy;
   logic         ovf_err;

   int checks   = 0;
   int failures = 0;
   int ready_mode = 0;   // 0 random, 1 always high, 2 always low
   int blk_count  = 0;

   logic [256:0] exp_q[$];
   logic [256:0] exp_ent;
   logic [255:0] held_data;
   logic         held_last;
   bit           chk_hold = 0;
   bit           chk_drop = 0;

   rpi_byte_to_block #(
      .SYNC_STAGES (SYNC_STAGES),
      .BLOCK_BYTES (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rpi_data  (rpi_data),
      .rpi_load  (rpi_load),
      .rpi_last  (rpi_last),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_last  (blk_last),
      .rpi_busy  (rpi_busy),
      .ovf_err   (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Message-level model: append 0x80, zero-fill to a whole number of blocks.
   task automatic push_blocks(input logic [7:0] msg[$], input bit with_last);
      logic [7:0]   padded[$];
      logic [255:0] d;
      int           nblk;
      padded = msg;
      if (with_last) begin
         padded.push_back(8'h80);
         while (padded.size() % 32 != 0) padded.push_back(8'h00);
      end
      nblk = padded.size() / 32;
      for (int b = 0; b < nblk; b++) begin
         d = '0;
         for (int i = 0; i < 32; i++) d = {d[247:0], padded[b*32+i]};
         exp_q.push_back({with_last && (b == nblk - 1), d});
      end
   endtask

   task automatic pulse_load(input logic [7:0] d, input bit l, input int w);
      @(negedge clk);
      rpi_data = d;
      rpi_last = l;
      #2 rpi_load = 1'b1;
      repeat (w) @(posedge clk);
      #3 rpi_load = 1'b0;
      repeat (SYNC_STAGES + 3) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input bit l, input int w);
      int n = 0;
      while (rpi_busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check_val("busy_timeout", 256'(rpi_busy), 256'(0));
      pulse_load(d, l, w);
   endtask

   // width 0 picks a random strobe width per byte; hold_idx gets hold_w.
   task automatic send_msg(input logic [7:0] msg[$], input bit with_last, input int width,
                           input int hold_idx, input int hold_w);
      int w;
      push_blocks(msg, with_last);
      for (int i = 0; i < msg.size(); i++) begin
         w = (width == 0) ? int'($urandom_range(1, 4)) : width;
         if (i == hold_idx) w = hold_w;
         send_byte(msg[i], with_last && (i == msg.size() - 1), w);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || rpi_busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check_val("drain_queue", 256'(exp_q.size()), 256'(0));
      check_val("drain_busy", 256'(rpi_busy), 256'(0));
   endtask

   // Ready driver, changed just after the active edge.
   initial begin
      blk_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       blk_ready = ($urandom_range(0, 2) != 0);
            1:       blk_ready = 1'b1;
            default: blk_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: compare blocks on handshake, check hold and valid drop.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk_hold = 0;
         chk_drop = 0;
      end else begin
         if (chk_hold) begin
            check_val("hold_valid", 256'(blk_valid), 256'(1));
            check_val("hold_data", blk_data, held_data);
            check_val("hold_last", 256'(blk_last), 256'(held_last));
         end
         if (chk_drop) check_val("valid_drop", 256'(blk_valid), 256'(0));
         chk_hold = 0;
         chk_drop = 0;
         if (blk_valid && blk_ready) begin
            blk_count++;
            $display("blk %0d last=%0b data=%h", blk_count, blk_last, blk_data);
            if (exp_q.size() == 0) begin
               check_val("unexpected_blk", 256'(blk_valid), 256'(0));
            end else begin
               exp_ent = exp_q.pop_front();
               check_val("blk_data", blk_data, exp_ent[255:0]);
               check_val("blk_last", 256'(blk_last), 256'(exp_ent[256]));
            end
            chk_drop = 1;
         end else if (blk_valid) begin
            chk_hold  = 1;
            held_data = blk_data;
            held_last = blk_last;
         end
      end
   end

   initial begin
      logic [7:0] m[$];
      rst_n    = 1'b0;
      rpi_data = 8'h00;
      rpi_load = 1'b0;
      rpi_last = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_val("rst_valid", 256'(blk_valid), 256'(0));
      check_val("rst_last", 256'(blk_last), 256'(0));
      check_val("rst_busy", 256'(rpi_busy), 256'(0));
      check_val("rst_ovf", 256'(ovf_err), 256'(0));
      check_val("rst_data", blk_data, 256'(0));
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // 32 counting bytes, no last, ready always high.
      ready_mode = 1;
      m = {};
      for (int i = 0; i < 32; i++) m.push_back(8'(i));
      send_msg(m, 1'b0, 0, -1, 0);
      wait_idle();

      // Short message padded in the same block.
      m = {8'hAA, 8'hBB, 8'hCC};
      send_msg(m, 1'b1, 0, -1, 0);
      wait_idle();

      // Full 32-byte message forcing a padding-only block; 2-cycle strobes.
      ready_mode = 0;
      m = {};
      for (int i = 0; i < 32; i++) m.push_back(8'($urandom));
      send_msg(m, 1'b1, 2, -1, 0);
      wait_idle();

      // Random-length messages with random ready.
      for (int k = 0; k < 8; k++) begin
         m = {};
         for (int i = 0; i < int'($urandom_range(1, 70)); i++) m.push_back(8'($urandom));
         send_msg(m, 1'b1, 0, -1, 0);
         wait_idle();
      end

      // Ready held low with a block pending; a stray strobe must be dropped.
      ready_mode = 2;
      m = {};
      for (int i = 0; i < 32; i++) m.push_back(8'($urandom));
      send_msg(m, 1'b0, 0, -1, 0);
      repeat (10) @(posedge clk);
      pulse_load(8'h55, 1'b0, 2);
      repeat (85) @(posedge clk);
      @(negedge clk);
      check_val("ovf_set", 256'(ovf_err), 256'(1));
      check_val("busy_held", 256'(rpi_busy), 256'(1));
      check_val("valid_held", 256'(blk_valid), 256'(1));
      ready_mode = 0;
      wait_idle();
      check_val("ovf_sticky", 256'(ovf_err), 256'(1));

      // Partial block discarded by reset; strobe high across reset release.
      for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0, 2);
      @(negedge clk);
      rst_n = 1'b0;
      rpi_data = 8'hEE;
      rpi_load = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #3 rpi_load = 1'b0;
      repeat (SYNC_STAGES + 3) @(posedge clk);
      @(negedge clk);
      check_val("rst_ovf_clr", 256'(ovf_err), 256'(0));
      check_val("rst_busy_clr", 256'(rpi_busy), 256'(0));
      m = {};
      for (int i = 0; i < 32; i++) m.push_back(8'(i + 8'h40));
      send_msg(m, 1'b0, 0, -1, 0);
      wait_idle();
      check_val("post_rst_ovf", 256'(ovf_err), 256'(0));

      // One very long strobe inside a message counts as a single byte.
      m = {};
      for (int i = 0; i < 40; i++) m.push_back(8'($urandom));
      send_msg(m, 1'b1, 0, 5, 3000);
      wait_idle();

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rpi_byte_to_block.md
RPI_BYTE_TO_BLOCK -- requirements
Module: rpi_byte_to_block

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for all Raspberry Pi inputs.
REQ-002 The block SHALL have parameter BLOCK_BYTES, default 32: bytes per message block; fixed at 32 for CubeHash-256.
REQ-003 clk  in  1  internal 100 MHz clock; the block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 rpi_data  in  8  message byte from the Pi, asynchronous, stable while rpi_load is high.
REQ-006 rpi_load  in  1  asynchronous strobe from the Pi; each rising edge presents one byte.
REQ-007 rpi_last  in  1  asynchronous; high with the final message byte.
REQ-008 blk_ready  in  1  hash core accepts a block.
REQ-009 blk_data  out  256  message block; byte 0 at bits 255:248, byte 31 at bits 7:0.
REQ-010 blk_valid  out  1  blk_data is valid.
REQ-011 blk_last  out  1  qualifies blk_valid; marks the final, padded block.
REQ-012 rpi_busy  out  1  the Pi SHALL NOT strobe while this is high.
REQ-013 ovf_err  out  1  sticky: a strobe arrived while busy.

Function
REQ-014 rpi_load, rpi_last and rpi_data SHALL each pass through SYNC_STAGES flops, followed by one edge-detect register; a strobe edge SHALL be detected SYNC_STAGES+1 cycles after the input rises.
REQ-015 Synchronized rpi_data and rpi_last SHALL be sampled in the detect cycle; the byte SHALL be written to position byte_cnt on the following edge, and byte_cnt SHALL then increment.
REQ-016 FSM states: COLLECT, PAD, OUT, OUT_PADBLK.
REQ-017 COLLECT: accept bytes. Go to OUT when byte_cnt reaches 32 without last. Go to PAD when a last byte lands at byte_cnt < 32. Go to OUT with pad_pending set when a last byte is the 32nd byte.
REQ-018 PAD (one cycle): write 0x80 at position byte_cnt, zero all higher positions, set blk_last, go to OUT.
REQ-019 OUT: blk_valid=1; blk_data and blk_last SHALL be held stable until a cycle with blk_valid && blk_ready.
REQ-020 On handshake from OUT: go to OUT_PADBLK if pad_pending is set, otherwise to COLLECT. In both cases clear byte_cnt and the block register; blk_valid SHALL be 0 on the next cycle.
REQ-021 OUT_PADBLK: present 0x80 followed by 31 zero bytes with blk_valid=1 and blk_last=1; on handshake go to COLLECT and clear pad_pending.
REQ-022 blk_ready asserted while blk_valid=0 SHALL be ignored.
REQ-023 rpi_busy SHALL be 1 in PAD, OUT and OUT_PADBLK, and 0 in COLLECT.
REQ-024 A strobe edge detected while rpi_busy=1 SHALL be dropped, leave the block unchanged, and set ovf_err until reset.
REQ-025 byte_cnt SHALL be 6 bits (0..32) and SHALL never wrap; a 33rd byte without a handshake is impossible by REQ-024.
REQ-026 Minimum block latency: blk_valid rises 1 cycle after the 32nd byte is written; a last-byte block rises 2 cycles after its write (via PAD).

Reset
REQ-027 While rst_n=0 on a clock edge: state=COLLECT, byte_cnt=0, blk_data=0, blk_valid=0, blk_last=0, rpi_busy=0, ovf_err=0, pad_pending=0, and all synchronizer and edge flops cleared.
REQ-028 Reset mid-block or during OUT SHALL discard the partial or pending block; a strobe already high when reset releases SHALL NOT be detected as an edge.

Structure
REQ-029 A shared package SHALL hold BLOCK_BYTES, the PAD_BYTE constant 8'h80 and the FSM state encoding.
REQ-030 One sub-module SHALL be used: sync_edge (an N-stage synchronizer plus rising-edge pulse), instantiated for rpi_load, with plain synchronizer stages for data and last.

Verification
REQ-031 32 strobes with bytes 0x00..0x1F, no last, blk_ready=1 -> one block 0x000102...1F, blk_valid for 1 cycle, blk_last=0.
REQ-032 3 bytes 0xAA,0xBB,0xCC, the third with last -> block 0xAABBCC80 followed by 28 zero bytes, blk_last=1.
REQ-033 32 bytes, the 32nd with last -> block 1 holds the data with blk_last=0; block 2 is 0x80 followed by 31 zero bytes with blk_last=1.
REQ-034 blk_ready held low for 100 cycles after blk_valid; strobe a byte meanwhile -> blk_data stable, byte dropped, ovf_err=1, rpi_busy=1 until ready.
REQ-035 Drop rst_n after 10 bytes, then send 32 new bytes -> first block contains only the new bytes, ovf_err=0.
REQ-036 rpi_load pulse width of 2 clk cycles, and rpi_load held high for 1e6 cycles -> exactly one byte accepted per rising edge.
